fpu_wb_arbiter: RTL

//   Writeback arbiter for the single FP register-file write port (we4/a4/wd4).
//   - Merges results from the fixed-latency FMA/convert pipe and the iterative divide/sqrt unit.
//   - NaN-boxes single-precision results.
//   - Registers the write toward the register file, which commits it on the following negedge.
//   - Exposes a pending-write query for hazard/stall logic.

---
 rtl/fpu_wb_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter
//   Writeback arbiter for the single FP register-file write port.
//   The fixed-latency FMA/convert pipe cannot be stalled, so it always wins.
//   Iterative divide/sqrt results go through a 2-entry FIFO. When the buffer
//   is empty and the pipe is idle, a divider result bypasses the FIFO.
//   Single-precision results are NaN-boxed when FLEN=64. The selected write
//   is registered, so it reaches the register file one cycle after selection.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   pipe_valid/rd/res/sgl FMA pipe result (no backpressure)
//   div_valid/rd/res/sgl  divider result, held until div_ready
//   div_ready             buffer has room (count < 2)
//   fwe/fwa/fwd           registered register-file write port
//   qa/qhit               hazard query: a write to qa is buffered or in flight
module fpu_wb_arbiter #(
   parameter int FLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pipe_valid,
   input  logic [4:0]      pipe_rd,
   input  logic [FLEN-1:0] pipe_res,
   input  logic            pipe_sgl,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [4:0]      div_rd,
   input  logic [FLEN-1:0] div_res,
   input  logic            div_sgl,
   output logic            fwe,
   output logic [4:0]      fwa,
   output logic [FLEN-1:0] fwd,
   input  logic [4:0]      qa,
   output logic            qhit
);

   // Buffer state. The 1-bit pointers wrap modulo DEPTH (=2) on their own.
   logic [1:0]      count_q, count_d;
   logic            head_q, head_d;
   logic            tail_q, tail_d;
   logic [4:0]      ent_rd_q  [DEPTH];
   logic [FLEN-1:0] ent_res_q [DEPTH];
   logic            ent_sgl_q [DEPTH];

   // Output register
   logic            fwe_q, fwe_d;
   logic [4:0]      fwa_q, fwa_d;
   logic [FLEN-1:0] fwd_q, fwd_d;

   logic            div_xfer, deq, byp, enq;
   logic            sel_valid, sel_sgl;
   logic [4:0]      sel_rd;
   logic [FLEN-1:0] sel_res, sel_box;

   assign div_ready = (count_q < 2'd2);
   assign div_xfer  = div_valid & div_ready;

   always_comb begin
      deq       = 1'b0;
      byp       = 1'b0;
      sel_valid = 1'b0;
      sel_rd    = pipe_rd;
      sel_res   = pipe_res;
      sel_sgl   = pipe_sgl;
      if (pipe_valid) begin
         sel_valid = 1'b1;
      end else if (count_q != 2'd0) begin
         deq       = 1'b1;
         sel_valid = 1'b1;
         sel_rd    = ent_rd_q[head_q];
         sel_res   = ent_res_q[head_q];
         sel_sgl   = ent_sgl_q[head_q];
      end else if (div_xfer) begin
         byp       = 1'b1;
         sel_valid = 1'b1;
         sel_rd    = div_rd;
         sel_res   = div_res;
         sel_sgl   = div_sgl;
      end
      // Any accepted divider result that did not go straight out is queued.
      enq = div_xfer & ~byp;
   end

   generate
      if (FLEN == 64) begin : g_box
         assign sel_box = sel_sgl ? {32'hFFFF_FFFF, sel_res[31:0]} : sel_res;
      end else begin : g_nobox
         assign sel_box = sel_res;
      end
   endgenerate

   always_comb begin
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
      head_d  = head_q ^ deq;
      tail_d  = tail_q ^ enq;
      fwe_d   = sel_valid;
      fwa_d   = fwa_q;
      fwd_d   = fwd_q;
      if (sel_valid) begin
         fwa_d = sel_rd;
         fwd_d = sel_box;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         fwe_q   <= 1'b0;
         fwa_q   <= 5'd0;
         fwd_q   <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         fwe_q   <= fwe_d;
         fwa_q   <= fwa_d;
         fwd_q   <= fwd_d;
      end
   end

   // Entry payload needs no reset; occupancy is tracked by count/head.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_rd_q[tail_q]  <= div_rd;
         ent_res_q[tail_q] <= div_res;
         ent_sgl_q[tail_q] <= div_sgl;
      end
   end

   // An entry is live if the buffer is full, or it is the head of a 1-deep buffer.
   always_comb begin
      qhit = fwe_q & (fwa_q == qa);
      for (int i = 0; i < DEPTH; i++) begin
         if (((count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)))) &&
             (ent_rd_q[i] == qa))
            qhit = 1'b1;
      end
   end

   assign fwe = fwe_q;
   assign fwa = fwa_q;
   assign fwd = fwd_q;

   a_count_max: assert property (@(posedge clk) disable iff (reset) count_q <= 2'd2);
   a_no_enq_full: assert property (@(posedge clk) disable iff (reset)
                                   !(enq && (count_q == 2'd2)));

endmodule
